// File: rtl/lab2_truth_checker.sv
// lab2_truth_checker
// Watches a 3-input combinational circuit ({A,B,C} -> F) and checks every
// input index against an expected truth table. A vector is only sampled once
// it has been stable (with valid high) for STABLE_CYCLES extra edges, and only
// once per stable episode. Coverage, last observed values, a saturating
// mismatch count and the first failing index are reported.

module lab2_truth_checker #(
    parameter logic [7:0]  EXPECTED      = 8'b1110_1000,
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       clear,
    input  logic       valid,
    input  logic [2:0] abc,
    input  logic       f,
    output logic [7:0] covered,
    output logic [7:0] observed,
    output logic [3:0] err_cnt,
    output logic       err,
    output logic [2:0] first_err_idx,
    output logic       done,
    output logic       pass
);

    localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);
    localparam logic [3:0] STABLE_PRE = 4'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Saturating increment used by both the settle counter and the error count.
    function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] max);
        logic [3:0] res;
        if (val >= max) begin
            res = max;
        end else begin
            res = val + 4'd1;
        end
        return res;
    endfunction

    state_t     state_r;
    logic [3:0] vec_r;
    logic [3:0] stab_cnt_r;
    logic [7:0] covered_r;
    logic [7:0] observed_r;
    logic [3:0] err_cnt_r;
    logic       err_r;
    logic [2:0] first_err_idx_r;
    logic       done_r;

    logic [3:0] vec_s;
    logic       stable_s;
    logic       sample_s;
    logic       mismatch_s;

    // Stability and sample qualification derived from current inputs and settle state.
    always_comb begin
        vec_s      = {abc, f};
        stable_s   = 1'b0;
        sample_s   = 1'b0;
        mismatch_s = (f != EXPECTED[abc]);
        if (valid && (vec_s == vec_r)) begin
            stable_s = 1'b1;
        end else begin
            stable_s = 1'b0;
        end
        // The sample fires only on the single edge where the counter crosses into saturation.
        if (stable_s && (stab_cnt_r == STABLE_PRE) && (state_r == ST_RUN)) begin
            sample_s = 1'b1;
        end else begin
            sample_s = 1'b0;
        end
    end

    // Settle logic: register the observed vector and count consecutive identical edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_r      <= 4'd0;
            stab_cnt_r <= 4'd0;
        end else if (clear) begin
            vec_r      <= 4'd0;
            stab_cnt_r <= 4'd0;
        end else begin
            vec_r <= vec_s;
            if (stable_s) begin
                stab_cnt_r <= sat_inc(stab_cnt_r, STABLE_MAX);
            end else begin
                stab_cnt_r <= 4'd0;
            end
        end
    end

    // Checker FSM with coverage, observation and error bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            covered_r       <= 8'd0;
            observed_r      <= 8'd0;
            err_cnt_r       <= 4'd0;
            err_r           <= 1'b0;
            first_err_idx_r <= 3'd0;
            done_r          <= 1'b0;
        end else if (clear) begin
            state_r         <= ST_IDLE;
            covered_r       <= 8'd0;
            observed_r      <= 8'd0;
            err_cnt_r       <= 4'd0;
            err_r           <= 1'b0;
            first_err_idx_r <= 3'd0;
            done_r          <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (sample_s) begin
                        covered_r[abc]  <= 1'b1;
                        observed_r[abc] <= f;
                        if (mismatch_s) begin
                            err_cnt_r <= sat_inc(err_cnt_r, 4'd15);
                            if (!err_r) begin
                                err_r           <= 1'b1;
                                first_err_idx_r <= abc;
                            end
                        end
                    end
                    // Completion is seen one edge after the covering sample lands.
                    if (covered_r == 8'hFF) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign covered       = covered_r;
    assign observed      = observed_r;
    assign err_cnt       = err_cnt_r;
    assign err           = err_r;
    assign first_err_idx = first_err_idx_r;
    assign done          = done_r;
    assign pass          = done_r && (err_cnt_r == 4'd0);

endmodule

// File: tb/tb_lab2_truth_checker.sv
// Testbench for lab2_truth_checker: table-driven truth-table walk, directed
// corner sequences, and randomized traffic against a run-length reference model.

module tb_lab2_truth_checker;

    localparam logic [7:0] EXP = 8'b1110_1000;
    localparam int         SC  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       clear;
    logic       valid;
    logic [2:0] abc;
    logic       f;
    logic [7:0] covered;
    logic [7:0] observed;
    logic [3:0] err_cnt;
    logic       err;
    logic [2:0] first_err_idx;
    logic       done;
    logic       pass;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (phase: 0 idle, 1 run, 2 done).
    int         m_phase;
    int         m_prev;
    int         m_run;
    logic [7:0] m_cov;
    logic [7:0] m_obs;
    int         m_errs;
    bit         m_err;
    logic [2:0] m_first;

    always #5 clk = ~clk;

    lab2_truth_checker #(.EXPECTED(EXP), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .valid(valid),
        .abc(abc), .f(f), .covered(covered), .observed(observed), .err_cnt(err_cnt),
        .err(err), .first_err_idx(first_err_idx), .done(done), .pass(pass)
    );

    typedef struct {
        logic       start;
        logic       valid;
        logic [2:0] abc;
        logic       f;
        int         reps;
        logic [7:0] cov;
        logic [7:0] obs;
        logic [3:0] ecnt;
        logic       done;
        logic       pass;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_prev  = 0;
        m_run   = 0;
        m_cov   = 8'd0;
        m_obs   = 8'd0;
        m_errs  = 0;
        m_err   = 1'b0;
        m_first = 3'd0;
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".covered"}, 32'(covered), 32'(m_cov));
        check({tag, ".observed"}, 32'(observed), 32'(m_obs));
        check({tag, ".err_cnt"}, 32'(err_cnt), (m_errs > 15) ? 32'd15 : 32'(m_errs));
        check({tag, ".err"}, 32'(err), 32'(m_err));
        check({tag, ".first_err_idx"}, 32'(first_err_idx), 32'(m_first));
        check({tag, ".done"}, 32'(done), 32'(m_phase == 2));
        check({tag, ".pass"}, 32'(pass), 32'((m_phase == 2) && (m_errs == 0)));
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        int v;
        bit samp;
        bit go_done;
        v = int'({abc, f});
        if (clear) begin
            model_reset();
        end else begin
            if (valid && (v == m_prev)) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_run = 0;
            end
            m_prev  = v;
            samp    = (m_run == SC) && (m_phase == 1);
            go_done = (m_phase == 1) && (m_cov == 8'hFF);
            if (m_phase == 0 && start) m_phase = 1;
            if (go_done) m_phase = 2;
            if (samp) begin
                m_cov[abc] = 1'b1;
                m_obs[abc] = f;
                if (f != EXP[abc]) begin
                    m_errs++;
                    if (!m_err) begin
                        m_err   = 1'b1;
                        m_first = abc;
                    end
                end
            end
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    task automatic drive(input logic st, input logic cl, input logic v, input logic [2:0] a, input logic ff);
        start = st;
        clear = cl;
        valid = v;
        abc   = a;
        f     = ff;
    endtask

    task automatic run_index(input logic [2:0] a, input logic ff, input int reps, input string tag);
        drive(1'b0, 1'b0, 1'b1, a, ff);
        for (int i = 0; i < reps; i++) tick(tag);
    endtask

    task automatic clear_and_start(input string tag);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        tick({tag, ".clr"});
        drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        tick({tag, ".start"});
        start = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 3'd0, 1'b0, 1, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 3'd0, 1'b0, 3, 8'h01, 8'h00, 4'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 3'd1, 1'b0, 3, 8'h03, 8'h00, 4'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 3'd2, 1'b0, 3, 8'h07, 8'h00, 4'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 3'd3, 1'b1, 3, 8'h0F, 8'h08, 4'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 3'd4, 1'b0, 3, 8'h1F, 8'h08, 4'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 3'd5, 1'b1, 3, 8'h3F, 8'h28, 4'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 3'd6, 1'b1, 3, 8'h7F, 8'h68, 4'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 3'd7, 1'b1, 3, 8'hFF, 8'hE8, 4'd0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 3'd7, 1'b1, 1, 8'hFF, 8'hE8, 4'd0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 3'd7, 1'b1, 3, 8'hFF, 8'hE8, 4'd0, 1'b1, 1'b1};

        // Reset state.
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.covered", 32'(covered), 32'h0);
        check("reset.observed", 32'(observed), 32'h0);
        check("reset.err_cnt", 32'(err_cnt), 32'h0);
        check("reset.done_pass", 32'({done, pass, err}), 32'h0);
        rst_n = 1'b1;
        tick("idle");

        // Full truth-table walk, all correct.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].start, 1'b0, tbl[i].valid, tbl[i].abc, tbl[i].f);
            for (int r = 0; r < tbl[i].reps; r++) tick("walk");
            check($sformatf("tbl%0d.covered", i), 32'(covered), 32'(tbl[i].cov));
            check($sformatf("tbl%0d.observed", i), 32'(observed), 32'(tbl[i].obs));
            check($sformatf("tbl%0d.err_cnt", i), 32'(err_cnt), 32'(tbl[i].ecnt));
            check($sformatf("tbl%0d.done", i), 32'(done), 32'(tbl[i].done));
            check($sformatf("tbl%0d.pass", i), 32'(pass), 32'(tbl[i].pass));
        end

        // Same walk with index 3 wrong.
        clear_and_start("bad3");
        for (int i = 0; i < 8; i++) begin
            logic [2:0] idx;
            idx = 3'(i);
            run_index(idx, (i == 3) ? 1'b0 : EXP[idx], 3, "bad3");
        end
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        tick("bad3.fin");
        check("bad3.err", 32'(err), 32'h1);
        check("bad3.first", 32'(first_err_idx), 32'h3);
        check("bad3.err_cnt", 32'(err_cnt), 32'h1);
        check("bad3.done_pass", 32'({done, pass}), 32'b10);
        check("bad3.observed", 32'(observed), 32'hE0);

        // Long hold: exactly one sample per episode; short glitch is not sampled.
        clear_and_start("hold");
        run_index(3'd5, 1'b1, 20, "hold");
        check("hold.covered", 32'(covered), 32'h20);
        check("hold.err_cnt0", 32'(err_cnt), 32'h0);
        run_index(3'd5, 1'b0, 20, "hold.bad");
        check("hold.err_cnt1", 32'(err_cnt), 32'h1);
        run_index(3'd4, 1'b0, 1, "glitch");
        run_index(3'd6, 1'b1, 1, "glitch");
        run_index(3'd4, 1'b0, 3, "glitch");
        check("glitch.covered", 32'(covered), 32'h30);

        // Saturation of err_cnt with alternating re-arm.
        clear_and_start("sat");
        for (int i = 0; i < 20; i++) begin
            run_index(3'd0, 1'b1, 3, "sat");
            run_index(3'd1, 1'b0, 3, "sat");
        end
        check("sat.err_cnt", 32'(err_cnt), 32'd15);
        check("sat.first", 32'(first_err_idx), 32'h0);
        check("sat.err", 32'(err), 32'h1);

        // Async reset mid-RUN after 4 samples.
        clear_and_start("arst");
        for (int i = 0; i < 4; i++) begin
            logic [2:0] idx;
            idx = 3'(i);
            run_index(idx, EXP[idx], 3, "arst");
        end
        check("arst.pre_cov", 32'(covered), 32'h0F);
        rst_n = 1'b0;
        #2;
        model_reset();
        check("arst.covered", 32'(covered), 32'h0);
        check("arst.observed", 32'(observed), 32'h0);
        check("arst.flags", 32'({err, done, pass, err_cnt}), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [2:0] idx;
            idx = 3'(i);
            run_index(idx, EXP[idx], 4, "arst.nostart");
        end
        check("arst.nostart_cov", 32'(covered), 32'h0);

        // Vector already stable when RUN begins is not sampled.
        drive(1'b0, 1'b1, 1'b1, 3'd6, 1'b1);
        tick("pre.clr");
        run_index(3'd6, 1'b1, 6, "pre.idle");
        drive(1'b1, 1'b0, 1'b1, 3'd6, 1'b1);
        tick("pre.start");
        run_index(3'd6, 1'b1, 5, "pre.run");
        check("prestable.covered", 32'(covered), 32'h0);

        // clear together with start and a qualified sample.
        clear_and_start("cs");
        run_index(3'd2, 1'b0, 2, "cs");
        drive(1'b1, 1'b1, 1'b1, 3'd2, 1'b0);
        tick("cs.edge");
        check("cs.covered", 32'(covered), 32'h0);
        check("cs.flags", 32'({err, done, pass, err_cnt, first_err_idx}), 32'h0);
        run_index(3'd2, 1'b0, 5, "cs.idle");
        check("cs.idle_cov", 32'(covered), 32'h0);

        // Randomized traffic against the model.
        for (int seg = 0; seg < 3; seg++) begin
            clear_and_start("rnd");
            for (int it = 0; it < 150; it++) begin
                logic [2:0] a;
                logic       ff;
                logic       v;
                int         hold;
                a    = 3'($urandom_range(0, 7));
                ff   = ($urandom_range(0, 5) == 0) ? ~EXP[a] : EXP[a];
                v    = ($urandom_range(0, 7) != 0);
                hold = $urandom_range(1, 5);
                drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 80) == 0), v, a, ff);
                tick("rnd");
                start = 1'b0;
                clear = 1'b0;
                for (int h = 1; h < hold; h++) tick("rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
